// File: rtl/csr_intrpt_ctrl.sv
// Machine-mode CSR file and interrupt controller for the 3-stage RISC-V core.
// Optional 64-bit mcycle/mcycleh counter enabled by defining CSR_MCYCLE_EN.
module csr_intrpt_ctrl #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            timer_intrpt,
    input  logic            ext_intrpt,
    input  logic            instr_valid,
    input  logic [31:0]     pc_in,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            is_mret,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    output logic            trap_taken
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
`endif

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic            mstatus_mie_reg, mstatus_mie_next;
    logic            mstatus_mpie_reg, mstatus_mpie_next;
    logic            mie_mtie_reg, mie_mtie_next;
    logic            mie_meie_reg, mie_meie_next;
    logic            mip_mtip_reg, mip_mtip_next;
    logic            mip_meip_reg;
    logic [XLEN-1:0] mtvec_reg, mtvec_next;
    logic [XLEN-1:0] mepc_reg, mepc_next;
    logic [XLEN-1:0] mcause_reg, mcause_next;
`ifdef CSR_MCYCLE_EN
    logic [XLEN-1:0] mcycle_lo_reg, mcycle_lo_next;
    logic [XLEN-1:0] mcycle_hi_reg, mcycle_hi_next;
    logic [XLEN-1:0] mcycle_lo_inc;
    logic            mcycle_carry;
`endif

    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            csr_we;
    logic            ext_pend;
    logic            tmr_pend;
    logic            irq;
    logic            trap;
    logic            mret_go;
    logic [4:0]      cause;
    logic [31:0]     trap_base;
    logic [31:0]     trap_target;

    // Read mux: always reflects pre-edge state so rd gets the old value.
    always_comb begin
        old_val = '0;
        case (csr_addr)
            ADDR_MSTATUS: old_val = XLEN'({mstatus_mpie_reg, 3'b000, mstatus_mie_reg, 3'b000});
            ADDR_MIE:     old_val = XLEN'({mie_meie_reg, 3'b000, mie_mtie_reg, 7'b000_0000});
            ADDR_MTVEC:   old_val = mtvec_reg;
            ADDR_MEPC:    old_val = mepc_reg;
            ADDR_MCAUSE:  old_val = mcause_reg;
            ADDR_MIP:     old_val = XLEN'({mip_meip_reg, 3'b000, mip_mtip_reg, 7'b000_0000});
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:  old_val = mcycle_lo_reg;
            ADDR_MCYCLEH: old_val = mcycle_hi_reg;
`endif
            default:      old_val = '0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (csr_op)
            OP_WRITE: new_val = csr_wdata;
            OP_SET:   new_val = old_val | csr_wdata;
            OP_CLEAR: new_val = old_val & ~csr_wdata;
            default:  new_val = old_val;
        endcase
    end

    assign csr_rdata = old_val;

    // Trap decision is purely combinational on the registered pending bits.
    assign ext_pend = mie_meie_reg & mip_meip_reg;
    assign tmr_pend = mie_mtie_reg & mip_mtip_reg;
    assign irq      = mstatus_mie_reg & (ext_pend | tmr_pend);
    assign trap     = irq & instr_valid;
    assign cause    = ext_pend ? 5'd11 : 5'd7;
    assign mret_go  = instr_valid & is_mret & ~trap;
    assign csr_we   = instr_valid & (csr_op != 2'b00) & ~trap;

    assign trap_base   = {mtvec_reg[31:2], 2'b00};
    assign trap_target = (mtvec_reg[1:0] == 2'b01) ? trap_base + {25'd0, cause, 2'b00}
                                                   : trap_base;

    assign redirect_valid = trap | mret_go;
    assign trap_taken     = trap;
    assign redirect_pc    = trap ? trap_target : mepc_reg;

    always_comb begin
        mstatus_mie_next  = mstatus_mie_reg;
        mstatus_mpie_next = mstatus_mpie_reg;
        mie_mtie_next     = mie_mtie_reg;
        mie_meie_next     = mie_meie_reg;
        mip_mtip_next     = mip_mtip_reg;
        mtvec_next        = mtvec_reg;
        mepc_next         = mepc_reg;
        mcause_next       = mcause_reg;

        if (trap) begin
            mstatus_mpie_next = mstatus_mie_reg;
            mstatus_mie_next  = 1'b0;
            mepc_next         = pc_in;
            mcause_next       = {1'b1, {(XLEN-6){1'b0}}, cause};
        end else if (mret_go) begin
            mstatus_mie_next  = mstatus_mpie_reg;
            mstatus_mpie_next = 1'b1;
        end else if (csr_we && csr_addr == ADDR_MSTATUS) begin
            mstatus_mie_next  = new_val[3];
            mstatus_mpie_next = new_val[7];
        end

        if (csr_we && csr_addr == ADDR_MIE) begin
            mie_mtie_next = new_val[7];
            mie_meie_next = new_val[11];
        end
        if (csr_we && csr_addr == ADDR_MTVEC) begin
            mtvec_next = {new_val[XLEN-1:2], 1'b0, new_val[0]};
        end
        if (csr_we && csr_addr == ADDR_MEPC) begin
            mepc_next = {new_val[XLEN-1:2], 2'b00};
        end
        if (csr_we && csr_addr == ADDR_MCAUSE) begin
            mcause_next = new_val;
        end

        // Timer pulse takes precedence over any clear landing in the same cycle.
        if (csr_we && csr_addr == ADDR_MIP) begin
            mip_mtip_next = new_val[7];
        end
        if (trap && !ext_pend) begin
            mip_mtip_next = 1'b0;
        end
        if (timer_intrpt) begin
            mip_mtip_next = 1'b1;
        end
    end

`ifdef CSR_MCYCLE_EN
    // A written half is replaced outright; the carry into the other half is dropped.
    assign {mcycle_carry, mcycle_lo_inc} = {1'b0, mcycle_lo_reg} + {{XLEN{1'b0}}, 1'b1};

    always_comb begin
        mcycle_lo_next = mcycle_lo_inc;
        mcycle_hi_next = mcycle_hi_reg + {{(XLEN-1){1'b0}}, mcycle_carry};
        if (csr_we && csr_addr == ADDR_MCYCLE) begin
            mcycle_lo_next = new_val;
            mcycle_hi_next = mcycle_hi_reg;
        end else if (csr_we && csr_addr == ADDR_MCYCLEH) begin
            mcycle_hi_next = new_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_lo_reg <= '0;
            mcycle_hi_reg <= '0;
        end else begin
            mcycle_lo_reg <= mcycle_lo_next;
            mcycle_hi_reg <= mcycle_hi_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_mtie_reg     <= 1'b0;
            mie_meie_reg     <= 1'b0;
            mip_mtip_reg     <= 1'b0;
            mip_meip_reg     <= 1'b0;
            mtvec_reg        <= MTVEC_RESET;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
        end else begin
            mstatus_mie_reg  <= mstatus_mie_next;
            mstatus_mpie_reg <= mstatus_mpie_next;
            mie_mtie_reg     <= mie_mtie_next;
            mie_meie_reg     <= mie_meie_next;
            mip_mtip_reg     <= mip_mtip_next;
            mip_meip_reg     <= ext_intrpt;
            mtvec_reg        <= mtvec_next;
            mepc_reg         <= mepc_next;
            mcause_reg       <= mcause_next;
        end
    end

endmodule

// File: tb/tb_csr_intrpt_ctrl.sv
// Table-driven bench for csr_intrpt_ctrl: each row is one execute-stage cycle,
// its expected outputs go through a queue and are checked on the falling edge.
module tb_csr_intrpt_ctrl;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        mret;
        logic        tmr;
        logic        ext;
        logic [31:0] e_rd;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_tt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        timer_intrpt;
    logic        ext_intrpt;
    logic        instr_valid;
    logic [31:0] pc_in;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        is_mret;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_taken;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   row_idx = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    csr_intrpt_ctrl #(.MTVEC_RESET(MTVEC_RST), .XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .timer_intrpt   (timer_intrpt),
        .ext_intrpt     (ext_intrpt),
        .instr_valid    (instr_valid),
        .pc_in          (pc_in),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .is_mret        (is_mret),
        .csr_rdata      (csr_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_taken     (trap_taken)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic iv, logic [31:0] pc, logic [1:0] op, logic [11:0] addr,
                                logic [31:0] wd, logic mret, logic tmr, logic ext,
                                logic [31:0] e_rd, logic e_rv, logic [31:0] e_rpc, logic e_tt);
        vec_t v;
        v.iv = iv; v.pc = pc; v.op = op; v.addr = addr; v.wd = wd;
        v.mret = mret; v.tmr = tmr; v.ext = ext;
        v.e_rd = e_rd; v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_tt = e_tt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        instr_valid  = v.iv;
        pc_in        = v.pc;
        csr_op       = v.op;
        csr_addr     = v.addr;
        csr_wdata    = v.wd;
        is_mret      = v.mret;
        timer_intrpt = v.tmr;
        ext_intrpt   = v.ext;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            vec_t e;
            e = exp_q.pop_front();
            chk("csr_rdata", row_idx, csr_rdata, e.e_rd);
            chk("redirect_valid", row_idx, {31'd0, redirect_valid}, {31'd0, e.e_rv});
            chk("trap_taken", row_idx, {31'd0, trap_taken}, {31'd0, e.e_tt});
            if (e.e_rv)
                chk("redirect_pc", row_idx, redirect_pc, e.e_rpc);
            $display("[TB] row %0d addr=%03h rdata=%08h rv=%0b tt=%0b rpc=%08h",
                     row_idx, e.addr, csr_rdata, redirect_valid, trap_taken, redirect_pc);
            row_idx++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; timer_intrpt = 1'b0; ext_intrpt = 1'b0; instr_valid = 1'b0;
        pc_in = '0; csr_op = '0; csr_addr = '0; csr_wdata = '0; is_mret = 1'b0;

        // Reset state of every CSR, including unimplemented space.
        tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h304, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h305, 0, 0, 0, 0, MTVEC_RST, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h341, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'hB00, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        // Timer trap in direct mode.
        tbl.push_back(mk(1, 32'h10, 1, 12'h300, 32'h8,   0, 0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h14, 1, 12'h304, 32'h80,  0, 0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h18, 1, 12'h305, 32'h100, 0, 0, 0, MTVEC_RST, 0, 0, 0));
        tbl.push_back(mk(1, 32'h40, 0, 12'h344, 0, 0, 1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(1, 32'h40, 0, 12'h344, 0, 0, 0, 0, 32'h80, 1, 32'h100, 1));
        tbl.push_back(mk(0, 0, 0, 12'h341, 0, 0, 0, 0, 32'h40, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 32'h8000_0007, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 32'h80, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 0, 0, 32'h0,  0, 0, 0));
        // mret restores MIE; pending MTIP waits for the next valid instruction.
        tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 1, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h44, 0, 12'h344, 0, 0, 0, 0, 32'h80, 0, 0, 0));
        tbl.push_back(mk(1, 32'h48, 0, 12'h300, 0, 1, 0, 0, 32'h80, 1, 32'h40, 0));
        tbl.push_back(mk(1, 32'h40, 0, 12'h300, 0, 0, 0, 0, 32'h88, 1, 32'h100, 1));
        tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        // CSR set in the trap cycle is discarded.
        tbl.push_back(mk(1, 32'h50, 1, 12'h300, 32'h8, 0, 0, 0, 32'h80, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 1, 0, 32'h08, 0, 0, 0));
        tbl.push_back(mk(1, 32'h80, 2, 12'h300, 32'h88, 0, 0, 0, 32'h08, 1, 32'h100, 1));
        tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 32'h80, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h341, 0, 0, 0, 0, 32'h80, 0, 0, 0));
        // Vectored mode, external beats timer, MTIP survives.
        tbl.push_back(mk(1, 32'h60, 1, 12'h305, 32'h103, 0, 0, 0, 32'h100, 0, 0, 0));
        tbl.push_back(mk(1, 32'h64, 1, 12'h304, 32'h880, 0, 0, 0, 32'h80, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h305, 0, 0, 1, 1, 32'h101, 0, 0, 0));
        tbl.push_back(mk(1, 32'h68, 1, 12'h300, 32'h8, 0, 0, 1, 32'h80, 0, 0, 0));
        tbl.push_back(mk(1, 32'h90, 0, 12'h344, 0, 0, 0, 1, 32'h880, 1, 32'h12C, 1));
        tbl.push_back(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 32'h8000_000B, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 0, 0, 32'h80, 0, 0, 0));
        // Software clears MTIP; MEIP is not software-writable.
        tbl.push_back(mk(1, 32'h70, 1, 12'h344, 32'h800, 0, 0, 0, 32'h80, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        // Pulse while idle for 5 cycles, then trap on first valid cycle.
        tbl.push_back(mk(1, 32'h74, 1, 12'h300, 32'h8, 0, 0, 0, 32'h80, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 1, 0, 32'h0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 0, 0, 32'h80, 0, 0, 0));
        tbl.push_back(mk(1, 32'hA0, 0, 12'h344, 0, 0, 0, 0, 32'h80, 1, 32'h11C, 1));
        tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        // Pulse coincides with a software clear: set wins.
        tbl.push_back(mk(1, 32'hA4, 3, 12'h344, 32'h80, 0, 1, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h344, 0, 0, 0, 0, 32'h80, 0, 0, 0));
        // Unimplemented write ignored; mepc low bits forced to zero.
        tbl.push_back(mk(1, 32'hA8, 1, 12'hB00, 32'hDEAD, 0, 0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'hB00, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'hAC, 1, 12'h341, 32'h123, 0, 0, 0, 32'hA0, 0, 0, 0));
        tbl.push_back(mk(1, 32'hB0, 0, 12'h300, 0, 1, 0, 0, 32'h80, 1, 32'h120, 0));
        tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 32'h88, 0, 0, 0));
        tbl.push_back(mk(1, 32'hB0, 0, 12'h342, 0, 0, 0, 0, 32'h8000_0007, 1, 32'h11C, 1));

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset in the middle of a trap cycle: pending MTIP is lost.
        apply(mk(1, 32'hB4, 1, 12'h300, 32'h8, 0, 0, 0, 32'h80, 0, 0, 0));
        apply(mk(0, 0, 0, 12'h344, 0, 0, 1, 0, 32'h0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1; instr_valid = 1'b1; pc_in = 32'hC0; csr_op = 2'b00; timer_intrpt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(mk(0, 0, 0, 12'h344, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        apply(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        apply(mk(0, 0, 0, 12'h341, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        apply(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        apply(mk(0, 0, 0, 12'h305, 0, 0, 0, 0, MTVEC_RST, 0, 0, 0));
        apply(mk(1, 32'hC0, 0, 12'h304, 0, 0, 0, 0, 32'h0, 0, 0, 0));

        instr_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/csr_intrpt_ctrl.md
Name: csr_intrpt_ctrl

Overview:
- Machine-mode CSR and interrupt controller for the 3-stage RISC-V core.
- Consumes the single-cycle timer interrupt pulse and an external interrupt level, and holds the M-mode trap CSRs.
- Decides trap entry and `mret` return, then drives a PC redirect into the fetch stage.
- Serves CSR read/write instructions issued from the execute stage.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- XLEN, 32, CSR data width; only 32 is supported.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- timer_intrpt  input  1  one-cycle pulse from the timer block
- ext_intrpt  input  1  level-sensitive external interrupt
- instr_valid  input  1  execute stage holds a valid, non-squashed instruction
- pc_in  input  32  PC of the execute-stage instruction
- csr_op  input  2  00 none, 01 write, 10 set, 11 clear
- csr_addr  input  12  CSR address
- csr_wdata  input  32  write/set/clear operand
- is_mret  input  1  execute-stage instruction is `mret`
- csr_rdata  output  32  combinational read data for csr_addr
- redirect_valid  output  1  redirect fetch this cycle; flush younger instructions
- redirect_pc  output  32  redirect target
- trap_taken  output  1  redirect is an interrupt entry (squash the execute-stage instruction)

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Reset values:
  - mstatus=0, mie=0, mip=0, mepc=0, mcause=0, mtvec=MTVEC_RESET.
  - Outputs derive from that state: redirect_valid=0, trap_taken=0.
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7; other bits read 0.
  - mie 0x304: MTIE bit7, MEIE bit11.
  - mtvec 0x305: base [31:2], mode [1:0]; mode bit1 is forced 0 on write.
  - mepc 0x341: bits [1:0] forced 0 on write.
  - mcause 0x342.
  - mip 0x344: MTIP bit7, MEIP bit11.
- Unimplemented address: read returns 0; write is ignored.
- CSR update:
  - new = wdata (01), old|wdata (10), old&~wdata (11).
  - Applied at the clock edge when instr_valid and no trap this cycle.
  - csr_rdata returns the old value, combinationally, for rd writeback.
- mip.MTIP:
  - Sticky; set by timer_intrpt.
  - Cleared by trap entry caused by the timer, or by a software write of 0.
  - A pulse in the same cycle as a clear leaves it set (set wins).
- mip.MEIP: registered copy of ext_intrpt, one cycle latency; software writes to bit11 are ignored.
- Interrupt request: irq = mstatus.MIE & ((mie.MEIE & MEIP) | (mie.MTIE & MTIP)).
- Trap entry:
  - Occurs when irq & instr_valid; purely combinational decision, no added latency.
  - Priority: external (cause 11) over timer (cause 7).
  - Same cycle: trap_taken=1, redirect_valid=1.
  - redirect_pc = {base,2'b00} in direct mode (mode=0), or {base,2'b00} + 4*cause in vectored mode (mode=1).
  - At the edge:
    - mepc <= pc_in.
    - mcause <= {1'b1, 31'(cause)}.
    - MPIE <= MIE; MIE <= 0.
    - MTIP cleared if cause=7.
  - The execute instruction is squashed: its CSR op and `mret` are discarded, and it re-executes after return.
- `mret` (instr_valid & is_mret & no trap):
  - Same cycle: redirect_valid=1, trap_taken=0, redirect_pc=mepc.
  - At the edge: MIE <= MPIE; MPIE <= 1.
- A pending interrupt re-enabled by `mret` is taken at the next valid instruction, never in the `mret` cycle itself.
- instr_valid=0: no trap, no CSR update, no `mret`; interrupts stay pending.
- Reset mid-trap or mid-`mret`: all state returns to reset values; a pending MTIP is lost.

Optional Feature:
- Macro: CSR_MCYCLE_EN.
- Defined:
  - Adds a 64-bit mcycle counter, reset 0, incrementing every cycle and wrapping at 2^64.
  - Readable/writable via mcycle 0xB00 (low) and mcycleh 0xB80 (high).
  - A write replaces the written half that cycle, with no increment for that half; the carry into the other half is suppressed that cycle.
- Undefined: 0xB00 and 0xB80 are unimplemented (read 0, writes ignored).

Test Plan:
- Reset, then read every CSR -> all 0, mtvec=MTVEC_RESET; redirect_valid=0.
- Set mstatus=0x8, mie=0x80, mtvec=0x100; pulse timer_intrpt with instr_valid=1, pc_in=0x40 -> next cycle: trap_taken=1, redirect_pc=0x100. After the edge: mepc=0x40, mcause=0x80000007, mstatus=0x80, mip bit7=0.
- mtvec=0x101 (vectored), mie=0x880, ext_intrpt=1 and MTIP pending, MIE=1 -> cause 11, redirect_pc=0x12C; MTIP stays 1.
- After a trap, `mret` with mepc=0x40 -> redirect_valid=1, trap_taken=0, redirect_pc=0x40; mstatus=0x88. Pending MTIP then traps on the next valid instruction.
- CSR set 0x88 on mstatus issued in the same cycle as a trap -> write discarded; csr_rdata=0x8; mstatus=0x80 after the edge.
- Timer pulse while instr_valid=0 for 5 cycles -> no redirect; MTIP held; trap on the first valid cycle. A pulse coinciding with a software clear of MTIP -> MTIP=1.
